// File: rtl/csa_self_test.sv
// Built-in self-test engine for the 4-operand, 4-bit carry-save adder.
// Sweeps all 65,536 operand sets and holds each one for SETTLE_CYCLES clocks.
// It then samples the adder sum and compares it with an internal reference.
// It reports a saturating error count, pass/fail and the first failing vector.
module csa_self_test #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned ERR_W         = 17
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic [3:0]       w,
  output logic [3:0]       x,
  output logic [3:0]       y,
  output logic [3:0]       z,
  input  logic [5:0]       s,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] error_count,
  output logic             fail_valid,
  output logic [15:0]      fail_vector,
  output logic [5:0]       fail_sum
);

  typedef enum logic [1:0] {StIdle, StSettle, StCheck, StDone} state_e;

  localparam logic [7:0] SettleLoad = 8'(SETTLE_CYCLES - 1);

  state_e      state_q;
  logic [15:0] idx_q;
  logic [7:0]  settle_cnt_q;
  logic [5:0]  ref_sum;
  logic        mismatch;

  // The operands come straight from the registered index, so they change only on index updates.
  assign w = idx_q[3:0];
  assign x = idx_q[7:4];
  assign y = idx_q[11:8];
  assign z = idx_q[15:12];

  // Reference sum of the current operands. The maximum is 60, so it fits in 6 bits.
  always_comb begin
    ref_sum  = {2'b00, w} + {2'b00, x} + {2'b00, y} + {2'b00, z};
    mismatch = (s != ref_sum);
  end

  assign pass = done & (error_count == '0);

  // Sequencer: walks idx, times the settle window and accumulates the results.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      settle_cnt_q <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error_count  <= '0;
      fail_valid   <= 1'b0;
      fail_vector  <= '0;
      fail_sum     <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q      <= StSettle;
            idx_q        <= '0;
            settle_cnt_q <= SettleLoad;
            busy         <= 1'b1;
            done         <= 1'b0;
            error_count  <= '0;
            fail_valid   <= 1'b0;
            fail_vector  <= '0;
            fail_sum     <= '0;
          end
        end
        StSettle: begin
          if (settle_cnt_q == 8'd0) begin
            state_q <= StCheck;
          end else begin
            settle_cnt_q <= settle_cnt_q - 8'd1;
          end
        end
        StCheck: begin
          if (mismatch) begin
            if (error_count != '1) begin
              error_count <= error_count + ERR_W'(1);
            end
            if (!fail_valid) begin
              fail_valid  <= 1'b1;
              fail_vector <= idx_q;
              fail_sum    <= s;
            end
          end
          if (idx_q == 16'hFFFF) begin
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            idx_q        <= idx_q + 16'd1;
            settle_cnt_q <= SettleLoad;
            state_q      <= StSettle;
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/csa_self_test.md
# csa_self_test

On-board built-in self-test engine for the 4-operand, 4-bit carry-save adder. It drives every one of the 65,536 operand combinations into the adder and samples the 6-bit sum after a programmable settle time. It compares each sum against an internally computed reference and reports a saturating mismatch count, pass/fail, and the first failing vector. It sits beside the adder in the Basys3 top level: operands go to the adder inputs, the adder sum comes back, and the status outputs go to LEDs and the seven-segment display.

## Interface
- SETTLE_CYCLES, 4, clock cycles each operand set is held before the sum is sampled; legal range 1..255.
- ERR_W, 17, width of the mismatch counter; 17 covers all 65,536 vectors without saturation.
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  level-sampled run request; honoured only in IDLE or DONE.
- w, x, y, z  out  4 each  operands driven to the adder.
- s  in  6  adder sum under test.
- busy  out  1  high while a run is in progress.
- done  out  1  high from the end of a run until the next start or reset.
- pass  out  1  valid when done=1; high iff error_count==0.
- error_count  out  ERR_W  number of mismatching vectors; saturates at all-ones.
- fail_valid  out  1  high once a mismatch has been captured in the current run.
- fail_vector  out  16  {z,y,x,w} of the first mismatch.
- fail_sum  out  6  value of s observed at the first mismatch.

## Operation
- FSM states: IDLE, SETTLE, CHECK, DONE.
- 16-bit index idx is the operand source: w=idx[3:0], x=idx[7:4], y=idx[11:8], z=idx[15:12]. w increments fastest and z slowest. Operands are registered and change only on edges that update idx.
- Reference sum is zero-extended w+x+y+z, 6 bits. The maximum is 60, so it never overflows.
- IDLE/DONE + start=1:
  - clear idx, error_count, fail_valid, fail_vector and fail_sum;
  - load settle counter with SETTLE_CYCLES-1;
  - go to SETTLE.
- SETTLE: if the counter is 0, go to CHECK; otherwise decrement.
- CHECK (one cycle): compare s with the reference.
  - On mismatch, error_count increments unless it is all-ones.
  - On a mismatch with fail_valid=0, capture idx into fail_vector and s into fail_sum, and set fail_valid.
  - If idx==16'hFFFF, go to DONE. Otherwise idx+1, reload the settle counter, and go to SETTLE.
- DONE: done=1, and pass=(error_count==0) combinationally. Holds all results until start.
- start while busy is ignored; the run continues unaffected.
- busy=1 in SETTLE and CHECK, 0 in IDLE and DONE.
- reset_n low at any time immediately forces:
  - state IDLE; idx, w/x/y/z, error_count, fail_* all 0;
  - busy=0, done=0, pass=0.
- No partial result survives a reset.

## Timing
- Edge E0 samples start=1. After E0: busy=1, idx=0, operands=0.
- Each vector occupies exactly SETTLE_CYCLES+1 edges: SETTLE_CYCLES edges in SETTLE, then 1 edge in CHECK.
- s for vector k is sampled on edge E0+(k+1)(SETTLE_CYCLES+1). The same edge advances the operands to vector k+1.
- done=1 and busy=0 take effect on edge E0+65536·(SETTLE_CYCLES+1). error_count is final on that same edge.
- A new start sampled in DONE behaves exactly as from IDLE: busy rises and done falls on that edge.
- The adder path must settle within SETTLE_CYCLES clock periods. The block provides no other guarantee.

## Test plan
- Correct behavioural adder, SETTLE_CYCLES=1, pulse start → done exactly 131,072 edges later; pass=1, error_count=0, fail_valid=0, busy low afterwards.
- Adder model with s stuck at 0 → error_count=65,535, fail_vector=16'h0001, fail_sum=0, pass=0.
- Adder model ignoring z (s=w+x+y) → error_count=61,440, fail_vector=16'h1000, fail_sum=0.
- ERR_W=8 with the stuck-at-0 model → error_count saturates at 255, pass=0, and the run still completes at the normal done time.
- start held high throughout a run → single run only; done rises once. Then pulse start again → a fresh run with counters cleared on that edge.
- Assert reset_n low asynchronously midway (idx≈0x4000) → all outputs 0 immediately with no clock. After release, state is IDLE until start; a fresh run then passes with the correct model.
